snn_image_loader: RTL



---
 rtl/snn_pkg.sv | 14 +
 rtl/snn_image_loader.sv | 98 +++++++++
 2 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN image loader.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int NUM_PIXELS_DEF  = 784;
  localparam int BYTES_PER_IMAGE = 98;

endpackage

// File: rtl/snn_image_loader.sv
// Unpacks UART bytes into a 1-bit pixel RAM, starts the SNN core after a full
// image and forwards its classification result back to the UART transmitter.
//
// state | meaning
// IDLE  | waiting for a byte (or holding the last result)
// SHIFT | writing the 8 pixel bits of one byte, LSB first
// START | one-cycle start pulse to the core
// RUN   | waiting for snn_done from the core
module snn_image_loader
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              snn_done,
  input  logic [3:0]        digit,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              snn_start,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [7:0]        led,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t            state;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        digit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      wr_addr  <= '0;
      digit_q  <= 4'h0;
      tx_start <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      // Bytes arriving while not idle are lost; only the sticky flag records it.
      if (rx_rdy && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            shreg   <= rx_data;
            bit_cnt <= 3'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (wr_addr == LAST_ADDR) begin
              wr_addr <= '0;
              state   <= START;
            end else begin
              wr_addr <= wr_addr + 1'b1;
              state   <= IDLE;
            end
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (snn_done) begin
            digit_q  <= digit;
            tx_start <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_we    = (state == SHIFT);
  assign ram_data  = ram_we & shreg[0];
  assign ram_addr  = ram_we ? wr_addr : core_addr;
  assign snn_start = (state == START);
  assign busy      = (state == SHIFT) || (state == RUN);
  assign tx_data   = {4'h0, digit_q};
  assign led       = tx_data;

endmodule
